mem_access_arbiter: RTL and testbench

- Shares the single port of one memory-under-test (single-port sync RAM, registered read) between NUM_REQ functional requesters and the MBIST memory interface.
- Functional requesters are served round-robin with a valid/ready handshake and a one-cycle read-response path.
- While mbist_run is high, the MBIST path owns the port exclusively once in-flight functional traffic has drained.
- Sits between the requesters/mem_interface outputs and the RAM macro.

---
 rtl/mem_access_arbiter_pkg.sv | 20 ++
 rtl/mem_access_arbiter_if.sv | 52 +++++
 rtl/mem_access_arbiter_rr_arbiter.sv | 58 +++++
 rtl/mem_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Purpose : shared types and constants for the memory access arbiter.
//   arb_state_t - port ownership states (idle, functional, draining, MBIST)
//   ARB_STAT_W  - width of the optional transfer statistics counters
//   idx_w()     - index width for an N-way requester vector (minimum 1)
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FUNC  = 2'd1,
    ARB_DRAIN = 2'd2,
    ARB_BIST  = 2'd3
  } arb_state_t;

  localparam int ARB_STAT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Purpose : bundles the requester handshake, MBIST side-band and RAM port
//           signals of the memory access arbiter.
// Modports:
//   slave  - the arbiter: consumes requests/MBIST controls/mem_q, drives
//            req_ready, rsp_*, bist_owned and mem_*.
//   master - the surrounding environment (requesters, mem_interface, RAM).
interface mem_access_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 7
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  logic                          mbist_run;
  logic                          bist_cs;
  logic                          bist_we;
  logic [ADDR_WIDTH-1:0]         bist_addr;
  logic [DATA_WIDTH-1:0]         bist_data;
  logic                          bist_owned;

  logic                          mem_cs;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_data;
  logic [DATA_WIDTH-1:0]         mem_q;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    input  mbist_run, bist_cs, bist_we, bist_addr, bist_data,
    output bist_owned,
    output mem_cs, mem_we, mem_addr, mem_data,
    input  mem_q
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    output mbist_run, bist_cs, bist_we, bist_addr, bist_data,
    input  bist_owned,
    input  mem_cs, mem_we, mem_addr, mem_data,
    output mem_q
  );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter.sv
// Purpose : NUM_REQ-wide round-robin picker.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer -> 0)
//   req       - request vector
//   en        - arbitration enable; no grant while low
//   accept    - the current grant completed a transfer; advance the pointer
//   gnt       - one-hot grant
//   gnt_idx   - index of the granted requester
//   gnt_vld   - a grant is being issued this cycle
module rr_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               accept,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] ptr;

  // Two passes: first the requesters at or above the pointer, then wrap to
  // the bottom of the vector. The first hit in either pass wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en && !gnt_vld && req[i[IDX_W-1:0]] && (i >= int'(ptr))) begin
        gnt_vld                = 1'b1;
        gnt_idx                = i[IDX_W-1:0];
        gnt[i[IDX_W-1:0]]      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en && !gnt_vld && req[i[IDX_W-1:0]]) begin
        gnt_vld                = 1'b1;
        gnt_idx                = i[IDX_W-1:0];
        gnt[i[IDX_W-1:0]]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && gnt_vld) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Purpose : shares the single port of a sync RAM (registered read, 1-cycle
//           latency) between NUM_REQ round-robin functional requesters and
//           the MBIST memory interface. While mbist_run is high the MBIST
//           side owns the port once in-flight functional reads have drained.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - mem_access_arbiter_if.slave: requester valid/ready and
//                packed payloads, per-owner read response pulse with shared
//                rsp_rdata, MBIST controls and bist_owned, RAM port mem_*/mem_q
//   stat_rd_cnt, stat_wr_cnt - saturating counts of accepted functional
//                reads/writes; present only when MEM_ARB_STATS_EN is defined
// Build option: `define MEM_ARB_STATS_EN to add the statistics counters.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [ARB_STAT_W-1:0] stat_rd_cnt,
  output logic [ARB_STAT_W-1:0] stat_wr_cnt
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);

  function automatic logic [ARB_STAT_W-1:0] sat_inc(input logic [ARB_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  arb_state_t             state;
  logic                   bist_owned_q;
  logic [NUM_REQ-1:0]     rsp_vld_p1;

  logic                   arb_en;
  logic [NUM_REQ-1:0]     gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_vld;

  logic [ADDR_WIDTH-1:0]  slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  slot_wdata[NUM_REQ];
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot_addr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign slot_wdata[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign sel_we    = bus.req_we[gnt_idx];
  assign sel_addr  = slot_addr[gnt_idx];
  assign sel_wdata = slot_wdata[gnt_idx];

  // A rising mbist_run suppresses any grant in the same cycle, so nothing
  // new enters flight once MBIST has asked for the port.
  assign arb_en = !rst && !bus.mbist_run &&
                  ((state == ARB_IDLE) || (state == ARB_FUNC));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .en      (arb_en),
    .accept  (gnt_vld),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Grants only exist where valid is high, so ready doubles as the transfer.
  assign bus.req_ready  = gnt;
  assign bus.rsp_valid  = rst ? '0 : rsp_vld_p1;
  assign bus.rsp_rdata  = (!rst && (|rsp_vld_p1)) ? bus.mem_q : '0;
  assign bus.bist_owned = bist_owned_q && !rst;

  always_comb begin
    bus.mem_cs   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_data = '0;
    if (bist_owned_q && !rst) begin
      bus.mem_cs   = bus.bist_cs;
      bus.mem_we   = bus.bist_we;
      bus.mem_addr = bus.bist_addr;
      bus.mem_data = bus.bist_data;
    end else if (gnt_vld) begin
      bus.mem_cs   = 1'b1;
      bus.mem_we   = sel_we;
      bus.mem_addr = sel_addr;
      bus.mem_data = sel_wdata;
    end
  end

  // ---- p0 -> p1: read accepted at this edge, response owner next cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      bist_owned_q <= 1'b0;
      rsp_vld_p1   <= '0;
    end else begin
      rsp_vld_p1 <= (gnt_vld && !sel_we) ? gnt : '0;
      case (state)
        ARB_IDLE: begin
          if (bus.mbist_run) begin
            state        <= ARB_BIST;
            bist_owned_q <= 1'b1;
          end else if (|bus.req_valid) begin
            state <= ARB_FUNC;
          end
        end
        ARB_FUNC: begin
          if (bus.mbist_run) begin
            state <= ARB_DRAIN;
          end else if (!(|bus.req_valid) && !(|rsp_vld_p1)) begin
            state <= ARB_IDLE;
          end
        end
        ARB_DRAIN: begin
          if (!(|rsp_vld_p1)) begin
            state        <= ARB_BIST;
            bist_owned_q <= 1'b1;
          end
        end
        ARB_BIST: begin
          if (!bus.mbist_run) begin
            state        <= ARB_IDLE;
            bist_owned_q <= 1'b0;
          end
        end
        default: begin
          state        <= ARB_IDLE;
          bist_owned_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Only functional transfers are counted; MBIST cycles never grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (gnt_vld) begin
      if (sel_we) stat_wr_cnt <= sat_inc(stat_wr_cnt);
      else        stat_rd_cnt <= sat_inc(stat_rd_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(7)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_wr_cnt;
`endif

  mem_access_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
`endif
  );

  // Single-port RAM, registered read.
  logic [6:0] ram [16];
  logic [6:0] ram_q = 7'h00;
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_q = ram_q;

  typedef struct {
    bit         owner;
    logic [6:0] data;
    int         at_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with no read outstanding (cycle %0d)",
                   bus.rsp_valid, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", int'(bus.rsp_valid), e.owner ? 2 : 1);
          chk("rsp_rdata", int'(bus.rsp_rdata), int'(e.data));
          chk("rsp_cycle", cyc, e.at_cyc);
        end
      end
    end
  end

  task automatic set_slot(input bit s, input logic v, input logic we,
                          input logic [3:0] a, input logic [6:0] d);
    if (s) begin
      bus.req_valid[1]    = v;
      bus.req_we[1]       = we;
      bus.req_addr[7:4]   = a;
      bus.req_wdata[13:7] = d;
    end else begin
      bus.req_valid[0]    = v;
      bus.req_we[0]       = we;
      bus.req_addr[3:0]   = a;
      bus.req_wdata[6:0]  = d;
    end
  endtask

  // One transfer from requester s. For reads, d is the expected read data.
  // Starts and returns just after a rising edge.
  task automatic op(input bit s, input logic we, input logic [3:0] a, input logic [6:0] d);
    bit got = 0;
    int n = 0;
    set_slot(s, 1'b1, we, a, we ? d : 7'h00);
    while (!got && n < 20) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) begin
        got = 1;
        chk("op_ready", int'(bus.req_ready), s ? 2 : 1);
        chk("op_mem_cs", int'(bus.mem_cs), 1);
        chk("op_mem_we", int'(bus.mem_we), int'(we));
        chk("op_mem_addr", int'(bus.mem_addr), int'(a));
        if (we) chk("op_mem_data", int'(bus.mem_data), int'(d));
        else    sb.push_back('{owner: s, data: d, at_cyc: cyc + 1});
      end
      @(posedge clk); #1;
      n++;
    end
    set_slot(s, 1'b0, 1'b0, 4'h0, 7'h00);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: requester %0d got no grant in 20 cycles, required a grant", s);
    end
  endtask

  task automatic wait_owned(input logic want, input string nm);
    int n = 0;
    @(negedge clk);
    while (bus.bist_owned !== want && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(bus.bist_owned), int'(want));
    @(posedge clk); #1;
  endtask

  logic [3:0] a0 [2] = '{4'h1, 4'h2};
  logic [3:0] a1 [2] = '{4'h7, 4'h8};
  logic [6:0] d0 [2] = '{7'h0F, 7'h70};
  logic [6:0] d1 [2] = '{7'h33, 7'h4C};
  int         exp_g [4] = '{0, 1, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, ng, n, g;
    rst           = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mbist_run = 1'b0;
    bus.bist_cs   = 1'b0;
    bus.bist_we   = 1'b0;
    bus.bist_addr = '0;
    bus.bist_data = '0;

    // ---- reset and idle ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_mem_cs", int'(bus.mem_cs), 0);
    chk("rst_bist_owned", int'(bus.bist_owned), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("idle_ready", int'(bus.req_ready), 0);
    chk("idle_rsp_valid", int'(bus.rsp_valid), 0);
    chk("idle_rsp_rdata", int'(bus.rsp_rdata), 0);
    chk("idle_bist_owned", int'(bus.bist_owned), 0);
    chk("idle_mem_cs", int'(bus.mem_cs), 0);
    chk("idle_mem_we", int'(bus.mem_we), 0);
    chk("idle_mem_addr", int'(bus.mem_addr), 0);
    chk("idle_mem_data", int'(bus.mem_data), 0);
`ifdef MEM_ARB_STATS_EN
    chk("rst_stat_rd", int'(stat_rd_cnt), 0);
    chk("rst_stat_wr", int'(stat_wr_cnt), 0);
`endif
    @(posedge clk); #1;

    // ---- write then read back on requester 0 ----
    op(1'b0, 1'b1, 4'h3, 7'h55);
    op(1'b0, 1'b0, 4'h3, 7'h55);

    // ---- preload; last transfer from requester 1 leaves the pointer at 0 ----
    op(1'b0, 1'b1, 4'h1, 7'h0F);
    op(1'b0, 1'b1, 4'h2, 7'h70);
    op(1'b1, 1'b1, 4'h7, 7'h33);
    op(1'b1, 1'b1, 4'h8, 7'h4C);

    // ---- both requesters reading continuously: grants 0,1,0,1 ----
    i0 = 0; i1 = 0; ng = 0; n = 0;
    while ((i0 < 2 || i1 < 2) && n < 20) begin
      set_slot(1'b0, i0 < 2, 1'b0, a0[i0 % 2], 7'h00);
      set_slot(1'b1, i1 < 2, 1'b0, a1[i1 % 2], 7'h00);
      @(negedge clk);
      g = -1;
      if (bus.req_ready == 2'b01) g = 0;
      else if (bus.req_ready == 2'b10) g = 1;
      else if (bus.req_ready != 2'b00) chk("rr_onehot", int'(bus.req_ready), 1);
      if (g >= 0) begin
        if (ng < 4) chk("rr_order", g, exp_g[ng]);
        if (g == 0) sb.push_back('{owner: 1'b0, data: d0[i0 % 2], at_cyc: cyc + 1});
        else        sb.push_back('{owner: 1'b1, data: d1[i1 % 2], at_cyc: cyc + 1});
        ng++;
      end
      @(posedge clk); #1;
      if (g == 0) i0++;
      if (g == 1) i1++;
      n++;
    end
    set_slot(1'b0, 1'b0, 1'b0, 4'h0, 7'h00);
    set_slot(1'b1, 1'b0, 1'b0, 4'h0, 7'h00);
    chk("rr_grants", ng, 4);
    chk("rr_back_to_back", n, 4);
    repeat (2) @(posedge clk); #1;

    // ---- read granted, mbist_run the next cycle: one DRAIN cycle ----
    bus.bist_cs = 1'b1; bus.bist_we = 1'b1; bus.bist_addr = 4'hA; bus.bist_data = 7'h12;
    op(1'b0, 1'b0, 4'h3, 7'h55);
    bus.mbist_run = 1'b1;
    set_slot(1'b1, 1'b1, 1'b0, 4'h7, 7'h00);
    @(negedge clk);
    chk("drain_req_suppressed", int'(bus.req_ready), 0);
    chk("drain_c1_owned", int'(bus.bist_owned), 0);
    chk("drain_c1_mem_cs", int'(bus.mem_cs), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_ready", int'(bus.req_ready), 0);
    chk("drain_owned", int'(bus.bist_owned), 0);
    chk("drain_mem_cs", int'(bus.mem_cs), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bist_owned", int'(bus.bist_owned), 1);
    chk("bist_ready", int'(bus.req_ready), 0);
    chk("bist_mem_cs", int'(bus.mem_cs), 1);
    chk("bist_mem_we", int'(bus.mem_we), 1);
    chk("bist_mem_addr", int'(bus.mem_addr), 32'hA);
    chk("bist_mem_data", int'(bus.mem_data), 32'h12);
    @(posedge clk); #1;
    bus.mbist_run = 1'b0;
    @(negedge clk);
    chk("bist_last_owned", int'(bus.bist_owned), 1);
    @(posedge clk); #1;
    bus.bist_cs = 1'b0; bus.bist_we = 1'b0;
    @(negedge clk);
    chk("bist_exit_owned", int'(bus.bist_owned), 0);
    chk("bist_exit_grant", int'(bus.req_ready), 2);
    chk("bist_exit_mem_addr", int'(bus.mem_addr), 7);
    sb.push_back('{owner: 1'b1, data: 7'h33, at_cyc: cyc + 1});
    @(posedge clk); #1;
    set_slot(1'b1, 1'b0, 1'b0, 4'h0, 7'h00);
    op(1'b0, 1'b0, 4'hA, 7'h12);
    repeat (3) @(posedge clk); #1;

    // ---- mbist_run and req_valid[1] rise together from IDLE ----
    bus.mbist_run = 1'b1;
    set_slot(1'b1, 1'b1, 1'b0, 4'h8, 7'h00);
    @(negedge clk);
    chk("simul_no_grant", int'(bus.req_ready), 0);
    chk("simul_mem_cs", int'(bus.mem_cs), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("simul_owned", int'(bus.bist_owned), 1);
    chk("simul_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    bus.mbist_run = 1'b0;
    @(negedge clk);
    chk("simul_owned_hold", int'(bus.bist_owned), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("simul_exit_owned", int'(bus.bist_owned), 0);
    chk("simul_req1_grant", int'(bus.req_ready), 2);
    sb.push_back('{owner: 1'b1, data: 7'h4C, at_cyc: cyc + 1});
    @(posedge clk); #1;
    set_slot(1'b1, 1'b0, 1'b0, 4'h0, 7'h00);
    repeat (2) @(posedge clk); #1;

    // ---- rst during BIST returns to IDLE ----
    bus.bist_cs = 1'b1; bus.bist_we = 1'b1; bus.bist_addr = 4'h4; bus.bist_data = 7'h5A;
    bus.mbist_run = 1'b1;
    wait_owned(1'b1, "bist_enter_owned");
    rst = 1'b1;
    bus.mbist_run = 1'b0;
    @(negedge clk);
    chk("bist_rst_owned", int'(bus.bist_owned), 0);
    chk("bist_rst_mem_cs", int'(bus.mem_cs), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_owned", int'(bus.bist_owned), 0);
    chk("post_rst_mem_cs", int'(bus.mem_cs), 0);
    @(posedge clk); #1;

    // ---- 3 writes and 5 reads with an MBIST session in between ----
    op(1'b0, 1'b1, 4'h9, 7'h01);
    op(1'b1, 1'b0, 4'h9, 7'h01);
    op(1'b1, 1'b1, 4'hF, 7'h7F);
    op(1'b0, 1'b0, 4'hF, 7'h7F);
    bus.mbist_run = 1'b1;
    wait_owned(1'b1, "stats_bist_owned");
    @(posedge clk); #1;
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_wr_bist_hold", int'(stat_wr_cnt), 2);
    chk("stat_rd_bist_hold", int'(stat_rd_cnt), 2);
    @(posedge clk); #1;
`endif
    bus.mbist_run = 1'b0;
    bus.bist_cs = 1'b0; bus.bist_we = 1'b0;
    wait_owned(1'b0, "stats_bist_release");
    op(1'b1, 1'b1, 4'h0, 7'h40);
    op(1'b0, 1'b0, 4'h0, 7'h40);
    op(1'b1, 1'b0, 4'hF, 7'h7F);
    op(1'b0, 1'b0, 4'h3, 7'h55);
    repeat (3) @(posedge clk); #1;
`ifdef MEM_ARB_STATS_EN
    chk("stat_wr_cnt", int'(stat_wr_cnt), 3);
    chk("stat_rd_cnt", int'(stat_rd_cnt), 5);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
